// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing one registered 4:1 mux across four producers
module mux_rr_arbiter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [3:0]       ack,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       lg_q, lg_d;
    logic [3:0]       ack_q, ack_d;

    logic [3:0]       elig;
    logic             found;
    logic [1:0]       pick;
    logic [1:0]       idx;
    logic [WIDTH-1:0] data_sel;
    logic             capture;

    // A channel acked last edge has not yet advanced its data, so mask it.
    assign elig = req & ~ack_q;

    always_comb begin
        found = 1'b0;
        pick  = 2'd0;
        idx   = 2'd0;
        for (int off = 1; off <= 4; off++) begin
            idx = lg_q + 2'(off);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        case (pick)
            2'd0:    data_sel = i0;
            2'd1:    data_sel = i1;
            2'd2:    data_sel = i2;
            default: data_sel = i3;
        endcase
    end

    // In BUSY a capture is only allowed on the edge that also consumes y.
    assign capture = found && ((state_q == IDLE) || y_ready);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        sel_d   = sel_q;
        lg_d    = lg_q;
        ack_d   = 4'b0000;
        if (capture) begin
            y_d   = data_sel;
            sel_d = pick;
            lg_d  = pick;
            ack_d = 4'b0001 << pick;
        end
        case (state_q)
            IDLE: if (found) state_d = BUSY;
            BUSY: if (y_ready && !found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            sel_q   <= 2'd0;
            lg_q    <= 2'd3;
            ack_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            lg_q    <= lg_d;
            ack_q   <= ack_d;
        end
    end

    assign ack     = ack_q;
    assign s1      = sel_q[1];
    assign s0      = sel_q[0];
    assign y       = y_q;
    assign y_valid = (state_q == BUSY);

endmodule
